prog_line_fill: RTL and testbench

//  Line-fill engine for the program cache. Accepts one miss request (line address), reads

---
 rtl/prog_line_fill.sv | 154 +++++++++++++++
 tb/tb_prog_line_fill.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_line_fill.sv
// Line-fill engine for the program cache.
// Takes one miss request and fetches the line one 32-bit word at a time. Each word uses an
// address handshake followed by a data response. The assembled line is then queued as
// {index, tag, data} in a small first-word-fall-through FIFO that the cache drains.
module prog_line_fill #(
    parameter int LINE_WIDTH     = 512,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH,
    parameter int INDEX_WIDTH    = 8,
    parameter int TAG_WIDTH      = 18,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [INDEX_WIDTH+TAG_WIDTH-1:0]  req_line_addr,
    output logic                              mem_rd_valid,
    output logic [31:0]                       mem_rd_addr,
    input  logic                              mem_rd_ready,
    input  logic                              mem_rsp_valid,
    input  logic [WORD_WIDTH-1:0]             mem_rsp_data,
    output logic                              fill_valid,
    input  logic                              fill_pop,
    output logic [INDEX_WIDTH-1:0]            fill_index,
    output logic [TAG_WIDTH-1:0]              fill_tag,
    output logic [LINE_WIDTH-1:0]             fill_data,
    output logic                              fifo_full,
    output logic                              fifo_empty,
    output logic                              busy
);

    localparam int CNT_W   = $clog2(WORDS_PER_LINE);
    localparam int LADDR_W = INDEX_WIDTH + TAG_WIDTH;
    localparam int BYTE_W  = 32 - LADDR_W - CNT_W;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        PUSH = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [LADDR_W-1:0]    line_addr;
    logic [CNT_W-1:0]      word_cnt;
    logic [LINE_WIDTH-1:0] line;
    logic                  accept;
    logic                  last_word;
    logic                  rsp_take;
    logic                  push;
    logic                  pop;

    logic [INDEX_WIDTH-1:0] fifo_index [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]   fifo_tag   [FIFO_DEPTH];
    logic [LINE_WIDTH-1:0]  fifo_data  [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [COUNT_W-1:0]     count;

    assign accept    = req_valid & req_ready;
    assign last_word = (word_cnt == CNT_W'(WORDS_PER_LINE - 1));
    assign rsp_take  = (state == DATA) & mem_rsp_valid;
    assign push      = (state == PUSH);
    assign pop       = fill_pop & ~fifo_empty;

    assign mem_rd_addr = (state == ADDR) ? {line_addr, word_cnt, {BYTE_W{1'b0}}} : 32'd0;

    // Next-state and handshake outputs; a request is only taken when the FIFO has a free
    // slot, so the later push can never overflow.
    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        mem_rd_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = ~fifo_full;
                if (req_valid && !fifo_full) state_next = ADDR;
            end
            ADDR: begin
                mem_rd_valid = 1'b1;
                if (mem_rd_ready) state_next = DATA;
            end
            DATA: begin
                if (mem_rsp_valid) state_next = last_word ? PUSH : ADDR;
            end
            PUSH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Word counter: cleared on accept, advanced after every word except the last.
    always_ff @(posedge clk) begin
        if (reset)                      word_cnt <= '0;
        else if (accept)                word_cnt <= '0;
        else if (rsp_take && !last_word) word_cnt <= word_cnt + 1'b1;
    end

    // Capture the line address of the accepted miss.
    always_ff @(posedge clk) begin
        if (accept) line_addr <= req_line_addr;
    end

    // Assemble the line: word k lands in bits [32k+31:32k] (little-endian byte order).
    always_ff @(posedge clk) begin
        if (rsp_take) line[int'(word_cnt) * WORD_WIDTH +: WORD_WIDTH] <= mem_rsp_data;
    end

    // FIFO storage write; the tag is the upper part of the line address, the index the lower.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_index[wr_ptr] <= line_addr[INDEX_WIDTH-1:0];
            fifo_tag[wr_ptr]   <= line_addr[LADDR_W-1:INDEX_WIDTH];
            fifo_data[wr_ptr]  <= line;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == COUNT_W'(FIFO_DEPTH));
    assign fill_valid = ~fifo_empty;
    assign fill_index = fifo_index[rd_ptr];
    assign fill_tag   = fifo_tag[rd_ptr];
    assign fill_data  = fifo_data[rd_ptr];

endmodule

// File: tb/tb_prog_line_fill.sv
// Bench for prog_line_fill: a memory responder with optional stall and delay, and a
// scoreboard of expected FIFO entries checked as the cache pops them.
module tb_prog_line_fill;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [25:0]  req_line_addr;
    logic         mem_rd_valid;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_ready;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         fill_valid;
    logic         fill_pop;
    logic [7:0]   fill_index;
    logic [17:0]  fill_tag;
    logic [511:0] fill_data;
    logic         fifo_full;
    logic         fifo_empty;
    logic         busy;

    prog_line_fill dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_line_addr (req_line_addr),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_ready  (mem_rd_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_valid    (fill_valid),
        .fill_pop      (fill_pop),
        .fill_index    (fill_index),
        .fill_tag      (fill_tag),
        .fill_data     (fill_data),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   idx;
        logic [17:0]  tag;
        logic [511:0] data;
    } ent_t;

    ent_t        sb[$];
    logic [25:0] exp_lines[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat;
    int          addr_chk = 0;

    // Control from the main sequence to the memory model (written only by main).
    int          arm_id = 0;
    int          stray_id = 0;
    int          stall_cfg = 0;
    int          delay_cfg = 0;
    logic [3:0]  word_cfg = 4'd0;
    logic [31:0] mem_base = 32'd0;

    // State of the memory model (written only by the model).
    int          arm_seen = 0;
    int          stray_seen = 0;
    int          stall_left = 0;
    int          delay_left = 0;
    bit          rsp_pending = 1'b0;
    int          rsp_wait = 0;
    logic [31:0] rsp_word = 32'd0;
    logic [31:0] addr_log [1024];
    int          addr_n = 0;
    logic [31:0] stall_log [16];
    int          stall_n = 0;
    logic [31:0] last_addr = 32'd0;

    // Memory model: decides ready/response at each falling edge, word k = base + k.
    initial begin
        mem_rd_ready  = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (arm_id != arm_seen) begin
                arm_seen   = arm_id;
                stall_left = stall_cfg;
                delay_left = delay_cfg;
            end
            mem_rsp_valid = 1'b0;
            if (stray_id != stray_seen) begin
                stray_seen    = stray_id;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hDEAD_BEEF;
            end else if (rsp_pending) begin
                if (rsp_wait == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = rsp_word;
                    rsp_pending   = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end
            mem_rd_ready = 1'b0;
            if (mem_rd_valid === 1'b1 && !rsp_pending) begin
                if (stall_left > 0 && mem_rd_addr[5:2] == word_cfg) begin
                    stall_left--;
                    if (stall_n < 16) stall_log[stall_n] = mem_rd_addr;
                    stall_n++;
                end else begin
                    mem_rd_ready = 1'b1;
                    if (addr_n < 1024) addr_log[addr_n] = mem_rd_addr;
                    addr_n++;
                    last_addr   = mem_rd_addr;
                    rsp_word    = mem_base + 32'(mem_rd_addr[5:2]);
                    rsp_pending = 1'b1;
                    rsp_wait    = 0;
                    if (delay_left > 0 && mem_rd_addr[5:2] == word_cfg) begin
                        rsp_wait   = delay_left;
                        delay_left = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_line(input logic [31:0] base);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    // Issue one request (must be accepted immediately); returns just after the handshake edge.
    task automatic start_fill(input logic [25:0] a, input logic [31:0] base);
        ent_t e;
        @(negedge clk);
        mem_base = base;
        e.idx  = a[7:0];
        e.tag  = a[25:8];
        e.data = exp_line(base);
        sb.push_back(e);
        exp_lines.push_back(a);
        req_line_addr = a;
        req_valid     = 1'b1;
        chk("req_ready_at_request", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Count cycles after the handshake until fill_valid is seen, bounded.
    task automatic wait_fill(output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (fill_valid !== 1'b1 && l < 300);
        chk("fill_arrival", fill_valid, 1'b1);
    endtask

    task automatic check_head(input string name);
        ent_t e;
        chk({name, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({name, "_index"}, fill_index, e.idx);
            chk({name, "_tag"},   fill_tag,   e.tag);
            chk({name, "_data"},  fill_data,  e.data);
        end
    endtask

    task automatic pop_check(input string name);
        @(negedge clk);
        chk({name, "_valid"}, fill_valid, 1'b1);
        check_head(name);
        fill_pop = 1'b1;
        @(posedge clk);
        #1 fill_pop = 1'b0;
    endtask

    task automatic check_addrs(input string name);
        logic [25:0] a;
        logic [31:0] ex;
        chk({name, "_lines_nonempty"}, exp_lines.size() != 0, 1'b1);
        if (exp_lines.size() != 0) begin
            a = exp_lines.pop_front();
            for (int k = 0; k < 16; k++) begin
                ex = {a, 6'b0} + 32'(4 * k);
                chk({name, "_rd_addr"}, (addr_chk < 1024) ? addr_log[addr_chk] : 32'hx, ex);
                addr_chk++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_line_addr = 26'd0;
        fill_pop      = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready",    req_ready,    1'b1);
        chk("rst_mem_rd_valid", mem_rd_valid, 1'b0);
        chk("rst_mem_rd_addr",  mem_rd_addr,  32'd0);
        chk("rst_fill_valid",   fill_valid,   1'b0);
        chk("rst_fifo_empty",   fifo_empty,   1'b1);
        chk("rst_fifo_full",    fifo_full,    1'b0);
        chk("rst_busy",         busy,         1'b0);

        // Single fill
        start_fill(26'h0000042, 32'hA000_0000);
        chk("t1_busy", busy, 1'b1);
        wait_fill(lat);
        chk("t1_latency", lat, 34);
        chk("t1_index",   fill_index, 8'h42);
        chk("t1_tag",     fill_tag, 18'h0);
        chk("t1_word0",   fill_data[31:0], 32'hA000_0000);
        chk("t1_word15",  fill_data[511:480], 32'hA000_000F);
        pop_check("t1_entry");
        check_addrs("t1");

        // Backpressure on word 5: 3 stalled address cycles, response 4 cycles late
        stall_cfg = 3;
        delay_cfg = 4;
        word_cfg  = 4'd5;
        arm_id++;
        start_fill(26'h0123456, 32'hB000_0000);
        wait_fill(lat);
        chk("t2_latency", lat, 41);
        chk("t2_stall_cycles", stall_n, 3);
        for (int i = 0; i < 3; i++)
            chk("t2_addr_hold", stall_log[i], {26'h0123456, 4'd5, 2'b00});
        pop_check("t2_entry");
        check_addrs("t2");

        // FIFO full holds off a third request until a pop
        start_fill(26'h0000100, 32'hC000_0000);
        wait_fill(lat);
        start_fill(26'h0000201, 32'hD000_0000);
        repeat (40) @(negedge clk);
        chk("t3_full",       fifo_full, 1'b1);
        chk("t3_ready_full", req_ready, 1'b0);
        begin
            ent_t e;
            mem_base = 32'hE000_0000;
            e.idx  = 8'h02;
            e.tag  = 18'h3;
            e.data = exp_line(32'hE000_0000);
            sb.push_back(e);
            exp_lines.push_back(26'h0000302);
            req_line_addr = 26'h0000302;
            req_valid     = 1'b1;
        end
        repeat (4) @(negedge clk);
        chk("t3_held_ready", req_ready, 1'b0);
        chk("t3_held_busy",  busy, 1'b0);
        pop_check("t3_first");
        chk("t3_ready_after_pop", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("t3_third_accepted", busy, 1'b1);
        repeat (40) @(negedge clk);
        chk("t3_full_again", fifo_full, 1'b1);
        pop_check("t3_second");
        pop_check("t3_third");
        check_addrs("t3a");
        check_addrs("t3b");
        check_addrs("t3c");

        // Push and pop in the same cycle with one entry queued, then pop on empty
        start_fill(26'h0000333, 32'h1111_0000);
        wait_fill(lat);
        start_fill(26'h0000444, 32'h2222_0000);
        repeat (33) @(negedge clk);
        chk("t4_busy_push", busy, 1'b1);
        check_head("t4_old_head");
        fill_pop = 1'b1;
        @(posedge clk);
        #1 fill_pop = 1'b0;
        @(negedge clk);
        chk("t4_valid_after", fill_valid, 1'b1);
        chk("t4_not_empty",   fifo_empty, 1'b0);
        chk("t4_not_full",    fifo_full,  1'b0);
        pop_check("t4_new_head");
        @(negedge clk);
        chk("t4_empty_before", fifo_empty, 1'b1);
        fill_pop = 1'b1;
        @(posedge clk);
        #1 fill_pop = 1'b0;
        @(negedge clk);
        chk("t4_empty_pop_empty", fifo_empty, 1'b1);
        chk("t4_empty_pop_valid", fill_valid, 1'b0);
        chk("t4_empty_pop_full",  fifo_full,  1'b0);
        check_addrs("t4d");
        check_addrs("t4e");

        // Reset during word 9 of a fill, then a stray response
        start_fill(26'h0055AA0, 32'h5000_0000);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        void'(sb.pop_back());
        void'(exp_lines.pop_back());
        @(negedge clk);
        chk("t5_busy",       busy, 1'b0);
        chk("t5_req_ready",  req_ready, 1'b1);
        chk("t5_rd_valid",   mem_rd_valid, 1'b0);
        chk("t5_empty",      fifo_empty, 1'b1);
        stray_id++;
        repeat (3) @(negedge clk);
        chk("t5_stray_busy",  busy, 1'b0);
        chk("t5_stray_empty", fifo_empty, 1'b1);
        chk("t5_stray_valid", fill_valid, 1'b0);
        chk("t5_stray_rd",    mem_rd_valid, 1'b0);
        addr_chk = addr_n;
        start_fill(26'h00000A7, 32'h7000_0000);
        wait_fill(lat);
        chk("t5_latency", lat, 34);
        pop_check("t5_entry");
        check_addrs("t5");

        // Tag/index split at the top of the address space
        start_fill(26'h3FFFFFF, 32'h6000_0000);
        wait_fill(lat);
        chk("t6_index", fill_index, 8'hFF);
        chk("t6_tag",   fill_tag, 18'h3FFFF);
        pop_check("t6_entry");
        check_addrs("t6");
        chk("t6_last_addr", last_addr, 32'hFFFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
